// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES-128 decrypt core between two requesters.
// Optional run-phase watchdog is built when AES_ARB_TIMEOUT_EN is defined.
module aes_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RELEASE_MIN    = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [1:0]   REQ,
    input  logic [127:0] KEY0,
    input  logic [127:0] KEY1,
    input  logic [127:0] MSG0,
    input  logic [127:0] MSG1,
    output logic [1:0]   ACK,
    output logic [127:0] RESULT,
    output logic [1:0]   ERR,
    output logic         BUSY,
    output logic         OWNER,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_EN,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_DE
);
    localparam int REL_W = $clog2(RELEASE_MIN + 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_MIN - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAP, S_REL} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      msg_q, msg_d;
    logic [127:0]      result_q, result_d;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic              grant;
    logic [1:0]        owner_oh;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        key_d     = key_q;
        msg_d     = msg_q;
        result_d  = result_q;
        rel_cnt_d = rel_cnt_q;
        grant     = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes next.
                if (|REQ) begin
                    grant   = (REQ == 2'b11) ? ~owner_q : REQ[1];
                    owner_d = grant;
                    key_d   = grant ? KEY1 : KEY0;
                    msg_d   = grant ? MSG1 : MSG0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef AES_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
                err_d    = 1'b0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (AES_DONE) begin
                    result_d = AES_MSG_DE;
                    state_d  = S_CAP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_CAP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            S_CAP: begin
                rel_cnt_d = '0;
                state_d   = S_REL;
            end
            S_REL: begin
                // Keeps START low long enough for the core to re-arm, and waits for the owner to drop REQ.
                if (rel_cnt_q != REL_LAST)
                    rel_cnt_d = rel_cnt_q + 1'b1;
                else if (!REQ[owner_q])
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b1;
            key_q     <= '0;
            msg_q     <= '0;
            result_q  <= '0;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            key_q     <= key_d;
            msg_q     <= msg_d;
            result_q  <= result_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    assign owner_oh   = owner_q ? 2'b10 : 2'b01;
    assign ACK        = (state_q == S_CAP) ? owner_oh : 2'b00;
    assign BUSY       = (state_q != S_IDLE);
    assign OWNER      = owner_q;
    assign AES_KEY    = key_q;
    assign AES_MSG_EN = msg_q;
    assign AES_START  = (state_q == S_RUN);
    assign RESULT     = result_q;

`ifdef AES_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign ERR = (state_q == S_CAP && err_q) ? owner_oh : 2'b00;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign ERR = 2'b00;
`endif

endmodule
